// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU group
// One quotient bit per cycle; special cases (divide by zero, signed overflow) skip the iteration.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [1:0]  div_op,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [1:0]  op_q, op_n;
  logic [31:0] divisor, divisor_n;
  logic [31:0] rem, rem_n;
  logic [31:0] quo, quo_n;
  logic [4:0]  cnt, cnt_n;
  logic        sign_q, sign_q_n;
  logic        sign_r, sign_r_n;
  logic        dvz, dvz_n;
  logic        ovf, ovf_n;
  logic        busy_n, done_n;
  logic [31:0] rd_n;

  logic        is_signed;
  logic        dvz_in, ovf_in;
  logic [31:0] abs1, abs2;
  logic [32:0] rem_sh, rem_sub;
  logic        ge;
  logic [31:0] result;

  assign is_signed = ~div_op[0];
  assign abs1      = (is_signed && rs1[31]) ? (~rs1 + 32'd1) : rs1;
  assign abs2      = (is_signed && rs2[31]) ? (~rs2 + 32'd1) : rs2;
  assign dvz_in    = (rs2 == 32'd0);
  assign ovf_in    = is_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

  // 33-bit partial remainder so the bit shifted out of rem[31] still takes part in the compare
  assign rem_sh  = {rem, quo[31]};
  assign ge      = (rem_sh >= {1'b0, divisor});
  assign rem_sub = rem_sh - {1'b0, divisor};

  always_comb begin
    result = 32'd0;
    if (dvz) begin
      // the dividend register holds the raw rs1 on a divide by zero
      result = op_q[1] ? quo : 32'hFFFF_FFFF;
    end else if (ovf) begin
      result = op_q[1] ? 32'd0 : 32'h8000_0000;
    end else if (op_q[1]) begin
      result = sign_r ? (~rem + 32'd1) : rem;
    end else begin
      result = sign_q ? (~quo + 32'd1) : quo;
    end
  end

  always_comb begin
    state_n   = state;
    op_n      = op_q;
    divisor_n = divisor;
    rem_n     = rem;
    quo_n     = quo;
    cnt_n     = cnt;
    sign_q_n  = sign_q;
    sign_r_n  = sign_r;
    dvz_n     = dvz;
    ovf_n     = ovf;
    done_n    = 1'b0;
    rd_n      = rd;

    case (state)
      IDLE: begin
        if (start) begin
          op_n      = div_op;
          divisor_n = abs2;
          rem_n     = 32'd0;
          cnt_n     = 5'd31;
          sign_q_n  = is_signed & (rs1[31] ^ rs2[31]);
          sign_r_n  = is_signed & rs1[31];
          dvz_n     = dvz_in;
          ovf_n     = ovf_in;
          if (dvz_in || ovf_in) begin
            quo_n   = rs1;
            state_n = FIN;
          end else begin
            quo_n   = abs1;
            state_n = CALC;
          end
        end
      end
      CALC: begin
        rem_n = ge ? rem_sub[31:0] : rem_sh[31:0];
        quo_n = {quo[30:0], ge};
        cnt_n = cnt - 5'd1;
        if (cnt == 5'd0) begin
          state_n = FIN;
        end
      end
      FIN: begin
        rd_n    = result;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (kill) begin
      state_n = IDLE;
      done_n  = 1'b0;
      rd_n    = rd;
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= 2'd0;
      divisor <= 32'd0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      cnt     <= 5'd0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      dvz     <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd      <= 32'd0;
    end else begin
      op_q    <= op_n;
      divisor <= divisor_n;
      rem     <= rem_n;
      quo     <= quo_n;
      cnt     <= cnt_n;
      sign_q  <= sign_q_n;
      sign_r  <= sign_r_n;
      dvz     <= dvz_n;
      ovf     <= ovf_n;
      busy    <= busy_n;
      done    <= done_n;
      rd      <= rd_n;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed and random scoreboard bench for div_unit
// Expected results and latencies are queued at launch and popped when done is seen.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [1:0]  div_op;
  logic        busy;
  logic        done;
  logic [31:0] rd;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] last_rd;

  div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .rs1    (rs1),
    .rs2    (rs2),
    .div_op (div_op),
    .busy   (busy),
    .done   (done),
    .rd     (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0: model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      2'd1: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2: model = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Launch one op now, optionally pulse a stray start mid-flight, wait for done and score it.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int stray_at);
    int          lat;
    logic        got;
    logic [31:0] e;
    int          el;
    exp_q.push_back(exp);
    lat_q.push_back(exp_lat);
    div_op = op;
    rs1    = a;
    rs2    = b;
    start  = 1'b1;
    lat    = 0;
    got    = 1'b0;
    while (!got && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        start  = 1'b0;
        rs1    = $urandom;
        rs2    = $urandom;
        div_op = 2'($urandom);
      end
      if (stray_at > 0 && lat == stray_at) begin
        start = 1'b1;
        rs2   = 32'd0;
      end else if (stray_at > 0 && lat == stray_at + 1) begin
        start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    check({tag, "_rd"}, rd, e);
    check({tag, "_latency"}, 32'(lat), 32'(el));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    last_rd = e;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int dones;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    n_checks = 0;
    n_fail   = 0;
    last_rd  = 32'd0;
    rst      = 1'b1;
    start    = 1'b0;
    kill     = 1'b0;
    rs1      = 32'd0;
    rs2      = 32'd0;
    div_op   = 2'd0;

    idle_cycles(2);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rd", rd, 32'd0);
    rst = 1'b0;
    idle_cycles(1);

    run_op("div_20_3", 2'd0, 32'd20, 32'd3, 32'd6, 34, 0);
    idle_cycles(2);
    run_op("rem_20_3", 2'd2, 32'd20, 32'd3, 32'd2, 34, 0);
    run_op("div_m20_3", 2'd0, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34, 0);
    run_op("rem_m20_3", 2'd2, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34, 0);
    run_op("rem_20_m3", 2'd2, 32'd20, 32'hFFFF_FFFD, 32'd2, 34, 0);
    run_op("divu_max_2", 2'd1, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34, 0);
    run_op("remu_max_16", 2'd3, 32'hFFFF_FFFF, 32'h10, 32'hF, 34, 0);
    idle_cycles(1);
    run_op("div_7_0", 2'd0, 32'd7, 32'd0, 32'hFFFF_FFFF, 2, 0);
    run_op("divu_7_0", 2'd1, 32'd7, 32'd0, 32'hFFFF_FFFF, 2, 0);
    run_op("remu_7_0", 2'd3, 32'd7, 32'd0, 32'd7, 2, 0);
    run_op("rem_m7_0", 2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2, 0);
    run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0);
    run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 0);
    run_op("divu_big", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 0);

    // stray start while busy: ignored, exactly one done
    idle_cycles(1);
    run_op("stray_start", 2'd0, 32'd100, 32'd7, 32'd14, 34, 10);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("stray_extra_done", 32'(dones), 32'd0);

    // kill at cycle 15: busy drops next cycle, no done, rd keeps prior value
    div_op = 2'd0;
    rs1    = 32'd1000;
    rs2    = 32'd10;
    start  = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("kill_busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_busy_after", 32'(busy), 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("kill_no_done", 32'(dones), 32'd0);
    check("kill_rd_held", rd, last_rd);

    // start together with kill in IDLE is dropped
    start = 1'b1;
    kill  = 1'b1;
    rs1   = 32'd9;
    rs2   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    kill  = 1'b0;
    check("start_kill_busy", 32'(busy), 32'd0);

    // back-to-back: second start is driven in the done cycle of the first
    run_op("b2b_first", 2'd1, 32'd1000, 32'd9, 32'd111, 34, 0);
    run_op("b2b_second", 2'd3, 32'd1000, 32'd9, 32'd1, 34, 0);

    // async reset between edges mid-CALC
    div_op = 2'd1;
    rs1    = 32'd5000;
    rs2    = 32'd7;
    start  = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    idle_cycles(9);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_rd", rd, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(1);
    run_op("after_rst", 2'd1, 32'd5000, 32'd7, 32'd714, 34, 0);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      if (i == 0) rb = 32'd0;
      if (i == 1) rb = 32'd1;
      run_op("random", rop, ra, rb, model(rop, ra, rb),
             ((rb == 0) || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 2 : 34, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
